fetch_queue_stage: RTL

Parametrised, decoupled instruction-fetch stage for the RV64I-Zba pipeline. It replaces the combinational PC+4 and instruction-memory path with a handshaked instruction-memory request/response port and supports multiple outstanding requests. It holds a circular fetch queue of {PC, instruction} entries between fetch and decode. A redirect from EX (branch, jump or flush) empties the queue and discards stale in-flight responses.

---
 rtl/fetch_queue_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Decoupled instruction-fetch stage: handshaked imem request/response port feeding a
// circular {pc, instr} queue toward decode; redirects flush the queue and drop stale responses.
module fetch_queue_stage #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     ILEN     = 32,
   parameter int unsigned     FQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            Redirect_F,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            Valid_D,
   output logic [XLEN-1:0] PC_D,
   output logic [ILEN-1:0] Instr_D,
   input  logic            Ready_D
);

   localparam int unsigned    PTR_W   = $clog2(FQ_DEPTH);
   localparam int unsigned    CNT_W   = $clog2(FQ_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = FQ_DEPTH[CNT_W:0];

   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]    head_q, head_d, fill_q, fill_d, tail_q, tail_d;
   logic [CNT_W-1:0]    alloc_q, alloc_d, drop_q, drop_d;
   // Allocated entries still waiting for their response.
   logic [CNT_W-1:0]    unf_q, unf_d;
   logic [FQ_DEPTH-1:0] filled_q, filled_d;
   logic [XLEN-1:0]     pc_q    [FQ_DEPTH];
   logic [ILEN-1:0]     instr_q [FQ_DEPTH];

   logic [CNT_W:0] inflight;
   logic           push, pop, rsp_drop, rsp_fill;

   assign inflight       = {1'b0, alloc_q} + {1'b0, drop_q};
   assign imem_req_valid = !rst && !Redirect_F && (inflight < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;
   assign push           = imem_req_valid && imem_req_ready;

   assign Valid_D = !rst && filled_q[head_q] && (alloc_q != '0);
   assign PC_D    = Valid_D ? pc_q[head_q] : '0;
   assign Instr_D = Valid_D ? instr_q[head_q] : '0;
   assign pop     = Valid_D && Ready_D && !Redirect_F;

   // Stale responses are consumed before any response may fill a live entry.
   assign rsp_drop = imem_rsp_valid && (drop_q != '0);
   assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (unf_q != '0) && !Redirect_F;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      fill_d     = fill_q;
      tail_d     = tail_q;
      alloc_d    = alloc_q;
      drop_d     = drop_q;
      unf_d      = unf_q;
      filled_d   = filled_q;
      if (Redirect_F) begin
         fetch_pc_d = PCTarget & ~XLEN'(3);
         head_d     = '0;
         fill_d     = '0;
         tail_d     = '0;
         alloc_d    = '0;
         unf_d      = '0;
         filled_d   = '0;
         drop_d     = drop_q + unf_q;
         if (imem_rsp_valid && (drop_d != '0)) drop_d = drop_d - 1'b1;
      end else begin
         if (push) begin
            fetch_pc_d       = fetch_pc_q + XLEN'(4);
            tail_d           = tail_q + 1'b1;
            filled_d[tail_q] = 1'b0;
         end
         if (rsp_drop) drop_d = drop_q - 1'b1;
         if (rsp_fill) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = fill_q + 1'b1;
         end
         if (pop) begin
            head_d           = head_q + 1'b1;
            filled_d[head_q] = 1'b0;
         end
         case ({push, pop})
            2'b10:   alloc_d = alloc_q + 1'b1;
            2'b01:   alloc_d = alloc_q - 1'b1;
            default: alloc_d = alloc_q;
         endcase
         case ({push, rsp_fill})
            2'b10:   unf_d = unf_q + 1'b1;
            2'b01:   unf_d = unf_q - 1'b1;
            default: unf_d = unf_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         fill_q     <= '0;
         tail_q     <= '0;
         alloc_q    <= '0;
         drop_q     <= '0;
         unf_q      <= '0;
         filled_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         fill_q     <= fill_d;
         tail_q     <= tail_d;
         alloc_q    <= alloc_d;
         drop_q     <= drop_d;
         unf_q      <= unf_d;
         filled_q   <= filled_d;
      end
   end

   // Payload storage needs no reset: visibility is governed by filled_q and alloc_q.
   always_ff @(posedge clk) begin
      if (push) pc_q[tail_q] <= fetch_pc_q;
      if (rsp_fill) instr_q[fill_q] <= imem_rsp_data;
   end

endmodule
